// File: rtl/alu_arbiter.sv
// Purpose: shares one 32-bit ALU between two requesters (round-robin or fixed priority) with a single result register.
// Latency: result visible with rvalid from just after the accepting edge until the edge that samples the owner's rready.
// Backpressure: while the result is held and its owner's rready=0, both request readies stay low; drain+accept is bubble-free.
//
// Ports:
//   clk, reset_n                  - rising-edge clock, asynchronous active-low reset
//   pX_valid/pX_ready             - request handshake for port X (X = 0, 1)
//   pX_a, pX_b, pX_op             - operands and 4-bit opcode for port X
//   pX_rvalid/pX_rready           - result handshake for port X
//   pX_result                     - result data (meaningful only while pX_rvalid)
//   busy                          - result register occupied
module alu_arbiter #(
    parameter bit PRIO_FIXED = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        p0_valid,
    output logic        p0_ready,
    input  logic [31:0] p0_a,
    input  logic [31:0] p0_b,
    input  logic [3:0]  p0_op,
    output logic        p0_rvalid,
    input  logic        p0_rready,
    output logic [31:0] p0_result,
    input  logic        p1_valid,
    output logic        p1_ready,
    input  logic [31:0] p1_a,
    input  logic [31:0] p1_b,
    input  logic [3:0]  p1_op,
    output logic        p1_rvalid,
    input  logic        p1_rready,
    output logic [31:0] p1_result,
    output logic        busy
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] res_q;
    logic        res_owner;
    logic        last_grant;

    logic        res_full;
    logic        drain;
    logic        can_accept;
    logic        grant;
    logic        accept;
    logic [31:0] sel_a;
    logic [31:0] sel_b;
    logic [3:0]  sel_op;

    function automatic logic [31:0] alu_fn(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [3:0]  op);
        logic [31:0] r;
        case (op)
            4'd0:    r = a + b;
            4'd1:    r = a - b;
            4'd2:    r = a & b;
            4'd3:    r = a | b;
            4'd4:    r = {b[15:0], 16'h0000};
            4'd5:    r = b << a[10:6];
            4'd6:    r = b >> a[10:6];
            4'd7:    r = a ^ b;
            default: r = a;
        endcase
        return r;
    endfunction

    assign res_full   = (state == FULL);
    // Only the owner's rready can free the register; the other port's is ignored.
    assign drain      = res_full && (res_owner ? p1_rready : p0_rready);
    assign can_accept = !res_full || drain;

    always_comb begin
        grant = 1'b0;
        if (p0_valid && p1_valid) begin
            grant = PRIO_FIXED ? 1'b0 : ~last_grant;
        end else if (p1_valid) begin
            grant = 1'b1;
        end
    end

    // reset_n is folded in so no request is acknowledged while reset is held.
    assign p0_ready = reset_n && can_accept && !grant && p0_valid;
    assign p1_ready = reset_n && can_accept &&  grant && p1_valid;
    assign accept   = p0_ready || p1_ready;

    assign sel_a  = grant ? p1_a  : p0_a;
    assign sel_b  = grant ? p1_b  : p0_b;
    assign sel_op = grant ? p1_op : p0_op;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= EMPTY;
            res_q      <= 32'h0;
            res_owner  <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state      <= FULL;
                        res_q      <= alu_fn(sel_a, sel_b, sel_op);
                        res_owner  <= grant;
                        last_grant <= grant;
                    end
                end
                FULL: begin
                    if (accept) begin
                        res_q      <= alu_fn(sel_a, sel_b, sel_op);
                        res_owner  <= grant;
                        last_grant <= grant;
                    end else if (drain) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign p0_rvalid = res_full && !res_owner;
    assign p1_rvalid = res_full &&  res_owner;
    assign p0_result = res_q;
    assign p1_result = res_q;
    assign busy      = res_full;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        p0_valid = 1'b0, p1_valid = 1'b0;
    logic [31:0] p0_a = '0, p0_b = '0, p1_a = '0, p1_b = '0;
    logic [3:0]  p0_op = '0, p1_op = '0;
    logic        p0_rready = 1'b0, p1_rready = 1'b0;

    // index 0: round-robin instance, index 1: fixed-priority instance
    logic [1:0]       rdy0, rdy1, rv0, rv1, bsy;
    logic [1:0][31:0] res0, res1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.PRIO_FIXED(1'b0)) dut (
        .clk(clk), .reset_n(reset_n),
        .p0_valid(p0_valid), .p0_ready(rdy0[0]), .p0_a(p0_a), .p0_b(p0_b), .p0_op(p0_op),
        .p0_rvalid(rv0[0]), .p0_rready(p0_rready), .p0_result(res0[0]),
        .p1_valid(p1_valid), .p1_ready(rdy1[0]), .p1_a(p1_a), .p1_b(p1_b), .p1_op(p1_op),
        .p1_rvalid(rv1[0]), .p1_rready(p1_rready), .p1_result(res1[0]),
        .busy(bsy[0])
    );

    alu_arbiter #(.PRIO_FIXED(1'b1)) dut_f (
        .clk(clk), .reset_n(reset_n),
        .p0_valid(p0_valid), .p0_ready(rdy0[1]), .p0_a(p0_a), .p0_b(p0_b), .p0_op(p0_op),
        .p0_rvalid(rv0[1]), .p0_rready(p0_rready), .p0_result(res0[1]),
        .p1_valid(p1_valid), .p1_ready(rdy1[1]), .p1_a(p1_a), .p1_b(p1_b), .p1_op(p1_op),
        .p1_rvalid(rv1[1]), .p1_rready(p1_rready), .p1_result(res1[1]),
        .busy(bsy[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Shifts expressed as multiply/divide by a power of two.
    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        longint unsigned pw = 1;
        longint unsigned bl = 64'(b);
        int s = int'(a[10:6]);
        for (int k = 0; k < s; k++) pw = pw * 2;
        if (op == 4'd0) return a + b;
        if (op == 4'd1) return a - b;
        if (op == 4'd2) return a & b;
        if (op == 4'd3) return a | b;
        if (op == 4'd4) return 32'((bl % 65536) * 65536);
        if (op == 4'd5) return 32'(bl * pw);
        if (op == 4'd6) return 32'(bl / pw);
        if (op == 4'd7) return a ^ b;
        return a;
    endfunction

    bit          m_full [2];
    bit          m_own  [2];
    logic [31:0] m_val  [2];
    bit          m_last [2];

    function automatic bit m_pick(input int i);
        if (p0_valid && p1_valid) return (i == 1) ? 1'b0 : !m_last[i];
        return p1_valid;
    endfunction

    function automatic bit m_room(input int i);
        return !m_full[i] || (m_own[i] ? p1_rready : p0_rready);
    endfunction

    function automatic bit m_rdy(input int i, input bit port);
        bit v = port ? p1_valid : p0_valid;
        return reset_n && m_room(i) && v && (m_pick(i) == port);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                m_full[i] = 1'b0;
                m_own[i]  = 1'b0;
                m_val[i]  = 32'h0;
                m_last[i] = 1'b1;
            end else begin
                automatic bit a0 = m_rdy(i, 1'b0);
                automatic bit a1 = m_rdy(i, 1'b1);
                automatic bit dr = m_full[i] && (m_own[i] ? p1_rready : p0_rready);
                if (a0 || a1) begin
                    m_full[i] = 1'b1;
                    m_own[i]  = a1;
                    m_last[i] = a1;
                    m_val[i]  = a1 ? ref_alu(p1_a, p1_b, p1_op) : ref_alu(p0_a, p0_b, p0_op);
                end else if (dr) begin
                    m_full[i] = 1'b0;
                end
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chkb($sformatf("m%0d.p0_ready", i), rdy0[i], m_rdy(i, 1'b0));
            chkb($sformatf("m%0d.p1_ready", i), rdy1[i], m_rdy(i, 1'b1));
            chkb($sformatf("m%0d.p0_rvalid", i), rv0[i], m_full[i] && !m_own[i]);
            chkb($sformatf("m%0d.p1_rvalid", i), rv1[i], m_full[i] && m_own[i]);
            chkb($sformatf("m%0d.busy", i), bsy[i], m_full[i]);
            if (m_full[i] && !m_own[i]) chk($sformatf("m%0d.p0_result", i), res0[i], m_val[i]);
            if (m_full[i] && m_own[i])  chk($sformatf("m%0d.p1_result", i), res1[i], m_val[i]);
            if (!reset_n) begin
                chk($sformatf("m%0d.p0_result_rst", i), res0[i], 32'h0);
                chk($sformatf("m%0d.p1_result_rst", i), res1[i], 32'h0);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [3:0]  sw_op  [5] = '{4'd5, 4'd6, 4'd7, 4'd4, 4'd9};
    logic [31:0] sw_exp [5] = '{32'h0000_0F10, 32'h0000_000F, 32'h0000_01F1, 32'h00F1_0000, 32'h0000_0100};

    initial begin
        // Reset state, with a request presented during reset.
        p0_valid = 1'b1; p0_a = 32'd5; p0_b = 32'd7; p0_op = 4'd0;
        p0_rready = 1'b1; p1_rready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chkb("rst_p0_ready", rdy0[0], 1'b0);
        chkb("rst_busy", bsy[0], 1'b0);
        chkb("rst_p0_rvalid", rv0[0], 1'b0);
        chk("rst_p0_result", res0[0], 32'h0);

        // Port 0 only.
        cyc(); reset_n = 1'b1;
        @(negedge clk);
        chkb("p0only_ready", rdy0[0], 1'b1);
        cyc(); p0_valid = 1'b0;
        @(negedge clk);
        chkb("p0only_rvalid", rv0[0], 1'b1);
        chk("p0only_result", res0[0], 32'd12);
        chkb("p0only_p1_rvalid", rv1[0], 1'b0);

        // Round-robin on the first instance, fixed priority on the second.
        cyc(); reset_n = 1'b0;
        cyc(); reset_n = 1'b1;
        p0_valid = 1'b1; p0_a = 32'd10; p0_b = 32'd3; p0_op = 4'd1;
        p1_valid = 1'b1; p1_a = 32'd0;  p1_b = 32'd1; p1_op = 4'd1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chkb($sformatf("rr_p0_ready_%0d", k), rdy0[0], (k % 2) == 0);
            chkb($sformatf("fx_p0_ready_%0d", k), rdy0[1], 1'b1);
            chkb($sformatf("fx_p1_ready_%0d", k), rdy1[1], 1'b0);
            chkb($sformatf("fx_p1_rvalid_%0d", k), rv1[1], 1'b0);
            if (k > 0) begin
                chkb($sformatf("rr_p0_rvalid_%0d", k), rv0[0], ((k - 1) % 2) == 0);
                if (((k - 1) % 2) == 0) chk($sformatf("rr_res_%0d", k), res0[0], 32'd7);
                else                    chk($sformatf("rr_res_%0d", k), res1[0], 32'hFFFF_FFFF);
                chk($sformatf("fx_res_%0d", k), res0[1], 32'd7);
            end
            cyc();
        end
        p0_valid = 1'b0; p1_valid = 1'b0;
        @(negedge clk);
        chkb("rr_last_p1_rvalid", rv1[0], 1'b1);
        chk("rr_last_res", res1[0], 32'hFFFF_FFFF);

        // Backpressure on port 0 with port 1 waiting.
        cyc();
        p0_valid = 1'b1; p0_a = 32'hF0F0_F0F0; p0_b = 32'h0FF0_0FF0; p0_op = 4'd2;
        p1_valid = 1'b1; p1_a = 32'd1; p1_b = 32'd2; p1_op = 4'd0;
        p0_rready = 1'b0; p1_rready = 1'b1;
        @(negedge clk);
        chkb("bp_accept_p0", rdy0[0], 1'b1);
        cyc(); p0_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("bp_res_%0d", k), res0[0], 32'h00F0_00F0);
            chkb($sformatf("bp_p0_ready_%0d", k), rdy0[0], 1'b0);
            chkb($sformatf("bp_p1_ready_%0d", k), rdy1[0], 1'b0);
            chkb($sformatf("bp_busy_%0d", k), bsy[0], 1'b1);
            if (k < 2) cyc();
        end
        cyc(); p0_rready = 1'b1;
        @(negedge clk);
        chkb("bp_drain_p1_ready", rdy1[0], 1'b1);
        cyc(); p1_valid = 1'b0;
        @(negedge clk);
        chkb("bp_p1_rvalid", rv1[0], 1'b1);
        chkb("bp_p0_rvalid", rv0[0], 1'b0);
        chk("bp_p1_result", res1[0], 32'd3);

        // Opcode sweep on port 1.
        p1_a = 32'h0000_0100; p1_b = 32'h0000_00F1; p1_rready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            p1_valid = 1'b1; p1_op = sw_op[i];
            @(negedge clk);
            if (i > 0) chk($sformatf("sweep_op%0d", sw_op[i-1]), res1[0], sw_exp[i-1]);
        end
        cyc(); p1_valid = 1'b0;
        @(negedge clk);
        chk("sweep_op9", res1[0], sw_exp[4]);

        // Asynchronous reset while holding a port 1 result.
        cyc();
        p1_valid = 1'b1; p1_a = 32'd1; p1_b = 32'd1; p1_op = 4'd0; p1_rready = 1'b0;
        cyc(); p1_valid = 1'b0;
        @(negedge clk);
        chkb("ar_pre_rvalid", rv1[0], 1'b1);
        chkb("ar_pre_busy", bsy[0], 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chkb("ar_rvalid", rv1[0], 1'b0);
        chkb("ar_busy", bsy[0], 1'b0);
        chk("ar_result", res1[0], 32'h0);
        cyc();
        cyc();
        reset_n = 1'b1;
        p0_valid = 1'b1; p0_a = 32'd2; p0_b = 32'd2; p0_op = 4'd0;
        p1_valid = 1'b1; p0_rready = 1'b1; p1_rready = 1'b1;
        @(negedge clk);
        chkb("ar_tie_p0_ready", rdy0[0], 1'b1);
        chkb("ar_tie_p1_ready", rdy1[0], 1'b0);
        cyc(); p0_valid = 1'b0; p1_valid = 1'b0;
        cyc();
        cyc();
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares a single 32-bit ALU datapath between two independent requesters, such as the EX stage and a secondary address/compare unit. It arbitrates with round-robin or fixed priority, accepts at most one operation per cycle over a valid/ready handshake, and holds each result in one output register. The result is returned to the requester that issued the operation, under per-port backpressure. The ALU function is computed combinationally inside the block on the granted operands.

## Interface
Parameters:
- PRIO_FIXED, 0, 0 = round-robin on ties; 1 = port 0 always wins ties

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- p0_valid  in  1  port 0 request valid
- p0_ready  out  1  port 0 request accepted this cycle (when p0_valid=1)
- p0_a, p0_b  in  32  port 0 operands A, B
- p0_op  in  4  port 0 ALU opcode
- p0_rvalid  out  1  port 0 result valid
- p0_rready  in  1  port 0 result consumed
- p0_result  out  32  port 0 result data
- p1_valid, p1_ready, p1_a, p1_b, p1_op, p1_rvalid, p1_rready, p1_result: same as port 0, for port 1
- busy  out  1  result register occupied

## Operation
- Opcodes, with all arithmetic modulo 2^32 and no flags:
  - 0: A+B
  - 1: A−B
  - 2: A&B
  - 3: A|B
  - 4: {B[15:0],16'h0}
  - 5: B<<A[10:6]
  - 6: B>>A[10:6] (logical)
  - 7: A^B
  - 8–15: A (pass-through)
- State: res_q[31:0], res_full, res_owner (0/1), last_grant (0/1).
- FSM has 2 states, EMPTY (res_full=0) and FULL (res_full=1).
  - EMPTY → FULL on accept.
  - FULL → FULL on drain and accept in the same cycle.
  - FULL → EMPTY on drain with no accept.
- drain = res_full && rready of res_owner.
- can_accept = !res_full || drain.
- Grant, computed combinationally:
  - Only one port valid: that port.
  - Both valid, PRIO_FIXED=1: port 0.
  - Both valid, PRIO_FIXED=0: the port ≠ last_grant.
- pX_ready = can_accept && grant==X && pX_valid. Ready may depend on valid, and ready never gates valid.
- Accept (pX_valid && pX_ready) at a clock edge does the following:
  - res_q ← ALU(pX_a, pX_b, pX_op)
  - res_full ← 1
  - res_owner ← X
  - last_grant ← X
- pX_rvalid = res_full && res_owner==X.
- p0_result and p1_result are both driven from res_q; each is meaningful only while its rvalid is high.
- busy = res_full.
- Requesters must hold operands stable while valid and not ready. The block samples them only at the accepting edge.

## Timing
- Reset (reset_n low, asynchronous, takes effect immediately):
  - res_full=0, res_q=0, res_owner=0, last_grant=1 (port 0 wins the first tie).
  - All rvalid=0, all results=0, busy=0.
  - All ready=0 while reset_n is low.
- Latency: an operation accepted at edge N has its result, with rvalid=1, visible from just after edge N until the edge at which rready=1 is sampled.
- Throughput: 1 operation per cycle when the owner holds rready=1 continuously. This includes back-to-back alternation between ports.
- Backpressure: while FULL and the owner's rready=0:
  - Both ready=0.
  - res_q, res_owner and rvalid are unchanged.
  - last_grant is unchanged.
- Simultaneous drain and accept: the old result is consumed and the new result is loaded at the same edge. There is no bubble.
- The non-owner's rready is ignored.
- Reset mid-operation: any held result is discarded with no response, and any pending request must be re-presented after reset.
- Arbitration is not sticky. If a port drops valid before it is accepted, no state changes.

## Test plan
- Port 0 only, reset idle: p0 A=5, B=7, op=0, p0_rready=1 → p0_ready=1 on the first cycle; next cycle p0_rvalid=1, p0_result=12; p1_rvalid=0 throughout.
- Round-robin: both ports valid for 4 cycles, rready=1.
  - p0: A=10, B=3, op=1.
  - p1: A=0, B=1, op=1.
  - Expected: grants 0,1,0,1; results 7, 32'hFFFF_FFFF, 7, 32'hFFFF_FFFF; rvalid alternates owner each cycle.
- Backpressure: p0 op=2, A=32'hF0F0_F0F0, B=32'h0FF0_0FF0, with p0_rready=0 for 3 cycles and p1_valid=1.
  - During stall: p0_result=32'h00F0_00F0 stable, p0_ready=p1_ready=0, busy=1.
  - On p0_rready=1: p1 is accepted at the same edge, and p1_rvalid rises next cycle.
- Opcode sweep on port 1 with A=32'h0000_0100 (shamt=4), B=32'h0000_00F1:
  - op5 → 32'h0000_0F10
  - op6 → 32'h0000_000F
  - op7 → 32'h0000_01F1
  - op4 → 32'h00F1_0000
  - op9 → 32'h0000_0100
- Asynchronous reset pulse mid-cycle while FULL (owner p1, rready=0) → p1_rvalid, busy and result drop to 0 without a clock edge. After release, a tie is granted to port 0 first.
- PRIO_FIXED=1, both ports valid continuously, rready=1 → port 0 is accepted every cycle, p1_ready stays 0, and p1_rvalid never asserts.
